// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file writeback initiator.
package regfile_wb_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic            live;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_if.sv
// Producer handshakes (ALU, LSU) and the register-file write port.
interface regfile_wb_if #(parameter int XLEN = regfile_wb_pkg::XLEN);

  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;

  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready,
    output rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready,
    input  rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/regfile_wb_queue.sv
// Circular buffer of pending LSU results with per-entry live bits and kill-by-rd.
module wb_queue
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq,
  input  logic [4:0]               enq_rd,
  input  logic [XLEN-1:0]          enq_data,
  input  logic                     pop,
  input  logic                     kill,
  input  logic [4:0]               kill_rd,
  output wb_entry_t                entries [DEPTH],
  output logic [$clog2(DEPTH)-1:0] head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] tail;

  // An entry enqueued in the same cycle as a kill is older than the killer, so it lands dead.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].live <= 1'b0;
      end
    end else begin
      if (kill) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (entries[i].rd == kill_rd) begin
            entries[i].live <= 1'b0;
          end
        end
      end
      if (enq) begin
        entries[tail].live <= !(kill && (enq_rd == kill_rd));
        entries[tail].rd   <= enq_rd;
        entries[tail].data <= enq_data;
        tail               <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      count <= count + {{AW{1'b0}}, enq} - {{AW{1'b0}}, pop};
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// Writeback initiator: arbitrates ALU and queued LSU results onto the register
// file write port and offers a two-port bypass of in-flight values.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_wb_if.slave            wb,
  input  logic [4:0]             byp_addr1,
  input  logic [4:0]             byp_addr2,
  output logic                   byp_hit1,
  output logic                   byp_hit2,
  output logic [XLEN-1:0]        byp_data1,
  output logic [XLEN-1:0]        byp_data2,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  wb_entry_t     entries [DEPTH];
  wb_entry_t     head_e;
  logic [AW-1:0] head;
  logic [AW:0]   count;
  logic          not_full;
  logic          alu_wr;
  logic          lsu_enq;
  logic          pop;

  // Readiness depends on occupancy only; a full queue stalls the ALU so the head drains.
  assign not_full     = (count < FULL);
  assign wb.alu_ready = not_full;
  assign wb.lsu_ready = not_full;
  assign q_count      = count;

  assign alu_wr  = wb.alu_valid && not_full && (wb.alu_rd != REG_ZERO);
  assign lsu_enq = wb.lsu_valid && not_full && (wb.lsu_rd != REG_ZERO);
  assign pop     = !alu_wr && (count != '0);
  assign head_e  = entries[head];

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .enq      (lsu_enq),
    .enq_rd   (wb.lsu_rd),
    .enq_data (wb.lsu_data),
    .pop      (pop),
    .kill     (alu_wr),
    .kill_rd  (wb.alu_rd),
    .entries  (entries),
    .head     (head),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wb.rf_we    <= 1'b0;
      wb.rf_waddr <= REG_ZERO;
      wb.rf_wdata <= '0;
    end else if (alu_wr) begin
      wb.rf_we    <= 1'b1;
      wb.rf_waddr <= wb.alu_rd;
      wb.rf_wdata <= wb.alu_data;
    end else if (pop && head_e.live) begin
      wb.rf_we    <= 1'b1;
      wb.rf_waddr <= head_e.rd;
      wb.rf_wdata <= head_e.data;
    end else begin
      wb.rf_we    <= 1'b0;
      wb.rf_waddr <= REG_ZERO;
      wb.rf_wdata <= '0;
    end
  end

  logic [4:0]      baddr [2];
  logic            bhit  [2];
  logic [XLEN-1:0] bdata [2];

  assign baddr[0]  = byp_addr1;
  assign baddr[1]  = byp_addr2;
  assign byp_hit1  = bhit[0];
  assign byp_hit2  = bhit[1];
  assign byp_data1 = bdata[0];
  assign byp_data2 = bdata[1];

  // Write stage is oldest; queue entries scanned oldest to youngest so the youngest match wins.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      bhit[p]  = 1'b0;
      bdata[p] = '0;
      if (baddr[p] != REG_ZERO) begin
        if (wb.rf_we && (wb.rf_waddr == baddr[p])) begin
          bhit[p]  = 1'b1;
          bdata[p] = wb.rf_wdata;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (((AW+1)'(i) < count) && entries[head + AW'(i)].live &&
              (entries[head + AW'(i)].rd == baddr[p])) begin
            bhit[p]  = 1'b1;
            bdata[p] = entries[head + AW'(i)].data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: expected writes go to a scoreboard queue, a monitor checks each rf write.
module tb_regfile_wb;
  import regfile_wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_if #(.XLEN(32)) wb ();

  logic [4:0]  byp_addr1 = 5'd0;
  logic [4:0]  byp_addr2 = 5'd0;
  logic        byp_hit1;
  logic        byp_hit2;
  logic [31:0] byp_data1;
  logic [31:0] byp_data2;
  logic [2:0]  q_count;

  regfile_wb #(.XLEN(32), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb),
    .byp_addr1 (byp_addr1),
    .byp_addr2 (byp_addr2),
    .byp_hit1  (byp_hit1),
    .byp_hit2  (byp_hit2),
    .byp_data1 (byp_data1),
    .byp_data2 (byp_data2),
    .q_count   (q_count)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t expq [$];
  exp_t exp_head;
  int   compared   = 0;
  int   mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    expq.push_back(e);
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                               input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    wb.alu_valid = av;
    wb.alu_rd    = ar;
    wb.alu_data  = ad;
    wb.lsu_valid = lv;
    wb.lsu_rd    = lr;
    wb.lsu_data  = ld;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Every register file write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && wb.rf_we === 1'b1) begin
      if (expq.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_write: got waddr=%0d wdata=0x%0h, expected no write",
                 wb.rf_waddr, wb.rf_wdata);
      end else begin
        exp_head = expq.pop_front();
        checkOutput("wb_waddr", 32'(wb.rf_waddr), 32'(exp_head.rd));
        checkOutput("wb_wdata", wb.rf_wdata, exp_head.data);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    byp_addr1 = 5'd5;
    byp_addr2 = 5'd0;
    #1;
    checkOutput("reset_rf_we",     32'(wb.rf_we), 32'd0);
    checkOutput("reset_rf_waddr",  32'(wb.rf_waddr), 32'd0);
    checkOutput("reset_rf_wdata",  wb.rf_wdata, 32'd0);
    checkOutput("reset_q_count",   32'(q_count), 32'd0);
    checkOutput("reset_alu_ready", 32'(wb.alu_ready), 32'd1);
    checkOutput("reset_lsu_ready", 32'(wb.lsu_ready), 32'd1);
    checkOutput("reset_byp_hit1",  32'(byp_hit1), 32'd0);
    checkOutput("reset_byp_hit2",  32'(byp_hit2), 32'd0);

    $display("[TB] ALU single write");
    pushExp(5'd5, 32'h11);
    applyStimulus(1, 5'd5, 32'h11, 0, 0, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("alu_rf_we",     32'(wb.rf_we), 32'd1);
    checkOutput("alu_byp_hit1",  32'(byp_hit1), 32'd1);
    checkOutput("alu_byp_data1", byp_data1, 32'h11);
    cycle();
    checkOutput("alu_rf_we_idle", 32'(wb.rf_we), 32'd0);

    $display("[TB] LSU fills queue behind ALU stream");
    pushExp(5'd7, 32'h70);
    pushExp(5'd7, 32'h71);
    pushExp(5'd7, 32'h72);
    pushExp(5'd7, 32'h73);
    pushExp(5'd3, 32'hAA);
    pushExp(5'd7, 32'h74);
    pushExp(5'd10, 32'hBB);
    pushExp(5'd11, 32'hCC);
    pushExp(5'd12, 32'hDD);
    applyStimulus(1, 5'd7, 32'h70, 1, 5'd3,  32'hAA); cycle();
    applyStimulus(1, 5'd7, 32'h71, 1, 5'd10, 32'hBB); cycle();
    applyStimulus(1, 5'd7, 32'h72, 1, 5'd11, 32'hCC); cycle();
    applyStimulus(1, 5'd7, 32'h73, 1, 5'd12, 32'hDD); cycle();
    applyStimulus(1, 5'd7, 32'h74, 0, 0, 0);
    byp_addr1 = 5'd3;
    byp_addr2 = 5'd7;
    #1;
    checkOutput("full_q_count",   32'(q_count), 32'd4);
    checkOutput("full_alu_ready", 32'(wb.alu_ready), 32'd0);
    checkOutput("full_lsu_ready", 32'(wb.lsu_ready), 32'd0);
    checkOutput("full_byp_hit1",  32'(byp_hit1), 32'd1);
    checkOutput("full_byp_data1", byp_data1, 32'hAA);
    checkOutput("full_byp_hit2",  32'(byp_hit2), 32'd1);
    checkOutput("full_byp_data2", byp_data2, 32'h73);
    cycle();
    checkOutput("drain_waddr",     32'(wb.rf_waddr), 32'd3);
    checkOutput("drain_q_count",   32'(q_count), 32'd3);
    checkOutput("drain_alu_ready", 32'(wb.alu_ready), 32'd1);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    checkOutput("drained_q_count", 32'(q_count), 32'd0);

    $display("[TB] ALU kills older LSU entry");
    pushExp(5'd9, 32'h2);
    applyStimulus(0, 0, 0, 1, 5'd9, 32'h1);
    cycle();
    applyStimulus(1, 5'd9, 32'h2, 0, 0, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    byp_addr1 = 5'd9;
    #1;
    checkOutput("kill_q_count",   32'(q_count), 32'd1);
    checkOutput("kill_byp_hit1",  32'(byp_hit1), 32'd1);
    checkOutput("kill_byp_data1", byp_data1, 32'h2);
    cycle();
    checkOutput("kill_pop_rf_we", 32'(wb.rf_we), 32'd0);
    checkOutput("kill_pop_count", 32'(q_count), 32'd0);

    $display("[TB] rd zero from both producers");
    applyStimulus(1, 5'd0, 32'h55, 1, 5'd0, 32'h66);
    byp_addr1 = 5'd0;
    #1;
    checkOutput("zero_alu_ready", 32'(wb.alu_ready), 32'd1);
    checkOutput("zero_lsu_ready", 32'(wb.lsu_ready), 32'd1);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("zero_q_count",  32'(q_count), 32'd0);
    checkOutput("zero_rf_we",    32'(wb.rf_we), 32'd0);
    checkOutput("zero_byp_hit1", 32'(byp_hit1), 32'd0);

    $display("[TB] youngest of two LSU entries to the same rd");
    pushExp(5'd8, 32'h80);
    pushExp(5'd8, 32'h81);
    pushExp(5'd4, 32'h10);
    pushExp(5'd4, 32'h20);
    applyStimulus(1, 5'd8, 32'h80, 1, 5'd4, 32'h10); cycle();
    applyStimulus(1, 5'd8, 32'h81, 1, 5'd4, 32'h20); cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    byp_addr1 = 5'd4;
    byp_addr2 = 5'd8;
    #1;
    checkOutput("dup_q_count",   32'(q_count), 32'd2);
    checkOutput("dup_byp_hit1",  32'(byp_hit1), 32'd1);
    checkOutput("dup_byp_data1", byp_data1, 32'h20);
    checkOutput("dup_byp_data2", byp_data2, 32'h81);
    cycle();
    checkOutput("dup_pop1_byp_data1", byp_data1, 32'h20);
    cycle();
    checkOutput("dup_pop2_byp_data1", byp_data1, 32'h20);
    cycle();

    $display("[TB] reset with queued entries");
    pushExp(5'd8, 32'h90);
    pushExp(5'd8, 32'h91);
    pushExp(5'd8, 32'h92);
    applyStimulus(1, 5'd8, 32'h90, 1, 5'd13, 32'hA1); cycle();
    applyStimulus(1, 5'd8, 32'h91, 1, 5'd14, 32'hA2); cycle();
    applyStimulus(1, 5'd8, 32'h92, 1, 5'd15, 32'hA3); cycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("prerst_q_count", 32'(q_count), 32'd3);
    @(negedge clk);
    #1;
    rst = 1'b1;
    cycle();
    checkOutput("rst_q_count", 32'(q_count), 32'd0);
    checkOutput("rst_rf_we",   32'(wb.rf_we), 32'd0);
    rst = 1'b0;
    repeat (6) cycle();
    checkOutput("postrst_q_count", 32'(q_count), 32'd0);

    checkOutput("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Writeback initiator for the 32×32 register file: collects results from the single-cycle ALU and the multi-cycle load/store unit (LSU), orders and arbitrates them, and drives the register file's single write port (`we`/`waddr`/`wdata`). It sits between the execute/memory stages and the register file. It also provides a two-port bypass lookup, so operand reads see writes that are still in flight.

## Interface
- `XLEN`, 32, data width; must match register file width.
- `DEPTH`, 4, LSU result queue entries; power of two, ≥2.
- `clk  in  1`: clock; all state updates on rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `alu_valid  in  1`: ALU result present.
- `alu_ready  out  1`: ALU result accepted this cycle.
- `alu_rd  in  5`: ALU destination register.
- `alu_data  in  XLEN`: ALU result.
- `lsu_valid  in  1`: LSU load result present.
- `lsu_ready  out  1`: LSU result accepted this cycle.
- `lsu_rd  in  5`: LSU destination register.
- `lsu_data  in  XLEN`: LSU result.
- `rf_we  out  1`: register file write enable.
- `rf_waddr  out  5`: register file write address.
- `rf_wdata  out  XLEN`: register file write data.
- `byp_addr1`, `byp_addr2  in  5`: operand read addresses, same as register file `raddr1`/`raddr2`.
- `byp_hit1`, `byp_hit2  out  1`: an in-flight value exists for that address.
- `byp_data1`, `byp_data2  out  XLEN`: the youngest in-flight value; valid only when the matching hit is 1.
- `q_count  out  $clog2(DEPTH)+1`: number of occupied queue entries.

## Operation
- Handshakes are valid/ready. A producer holds `rd` and `data` stable while valid is high and ready is low.
- `lsu_ready = (q_count < DEPTH)`. `alu_ready = (q_count < DEPTH)`. These signals are combinational from state only, never from the valid inputs.
- LSU acceptance enqueues the entry at the tail as live. When `lsu_rd == 0`, the result is accepted but not enqueued.
- Write-port arbitration each cycle:
  - An accepted ALU result with nonzero rd wins the port.
  - Otherwise the queue head is popped.
  - An ALU result with `rd == 0` is accepted without a write, and the queue head may pop in that cycle.
- When the queue is full, `alu_ready = 0`. The head therefore drains, which bounds LSU starvation at one cycle per full event.
- Ordering rule: an accepted ALU result is younger than every queued entry and than an LSU entry enqueued in the same cycle. Each such entry with matching rd has its live bit cleared ("killed").
- A killed entry still occupies its slot. Popping it takes one cycle and produces `rf_we = 0`.
- `rf_we` is never asserted with `rf_waddr == 0`.
- Bypass: among live queue entries matching `byp_addrN` (nonzero), the youngest wins. Otherwise the write stage wins if `rf_we` is high and `rf_waddr` matches. Otherwise the result is a miss.
- Bypass for address 0 always misses. The bypass path is combinational.

## Timing
- Reset values: `rf_we = 0`, `rf_waddr = 0`, `rf_wdata = 0`, `q_count = 0`, all entries not live.
  - `alu_ready = lsu_ready = 1` from the first cycle after reset.
  - `byp_hit* = 0`.
- `rf_*` outputs are registered. An ALU result accepted in cycle N produces `rf_we` in cycle N+1. The register file commits it at the end of N+1.
- LSU latency: enqueue in cycle N, then the earliest pop in N+1, then `rf_we` in N+2, delayed by any intervening ALU writes.
- Throughput: one register file write per cycle.
- Simultaneous enqueue and pop with the queue full: the pop happens, but `lsu_ready` was already 0, so there is no enqueue that cycle.
- Queue pointers wrap modulo `DEPTH`. `q_count` distinguishes full from empty.
- Reset mid-operation discards all queued and in-flight results. Results held by producers are re-offered after reset.

## Structure
- Package `regfile_wb_pkg`:
  - `XLEN` default.
  - Typedef `wb_entry_t {live, rd[4:0], data[XLEN-1:0]}`.
  - Constant `REG_ZERO = 5'd0`.
- Sub-module `wb_queue`: circular buffer with per-entry live bits and a kill-by-rd input. It exposes all entries for the bypass search.
- The top level holds arbitration, the write-stage registers, and the bypass priority logic.

## Test plan
- ALU rd=5, data=0x11 in cycle 0: `rf_we = 1`, `waddr = 5`, `wdata = 0x11` in cycle 1. `byp_hit1 = 1` with `byp_data1 = 0x11` in cycle 1 when `byp_addr1 = 5`.
- LSU rd=3, data=0xAA enqueued while the ALU writes rd=7 every cycle: the queue holds until it is full (4 entries), then `alu_ready = 0`, the head pops, and `waddr = 3`, `wdata = 0xAA` appears.
- LSU rd=9, data=0x1 queued, then ALU rd=9, data=0x2: the LSU entry is killed, the final register file write to 9 is 0x2, and the later pop has `rf_we = 0`.
- ALU rd=0 and LSU rd=0: both are accepted, no `rf_we`, `q_count` stays 0, and bypass for address 0 misses.
- Two LSU entries rd=4 (0x10, then 0x20) queued: bypass of 4 returns 0x20. The writes occur in order 0x10, then 0x20.
- Assert `rst` with 3 entries queued: next cycle `q_count = 0`, `rf_we = 0`, and no queued entry is ever written.
